// File: rtl/adder_arbiter.sv
// Round-robin front end that time-shares one external combinational adder among four requesters.
// Grant -> EXEC -> RESP, response held until resp_ready; ops_done counts accepted responses.
module adder_arbiter #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_cin,
  output logic [WIDTH-1:0]         add_a,
  output logic [WIDTH-1:0]         add_b,
  output logic                     add_cin,
  input  logic [WIDTH-1:0]         add_s,
  input  logic                     add_cout,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [WIDTH-1:0]         resp_sum,
  output logic                     resp_cout,
  output logic [1:0]               resp_id,
  output logic                     busy,
  output logic [15:0]              ops_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state_q;
  logic [1:0]         last_grant_q;
  logic [WIDTH-1:0]   cap_a_q;
  logic [WIDTH-1:0]   cap_b_q;
  logic               cap_cin_q;
  logic [1:0]         cap_id_q;
  logic               resp_valid_q;
  logic [WIDTH-1:0]   resp_sum_q;
  logic               resp_cout_q;
  logic [1:0]         resp_id_q;
  logic [15:0]        ops_done_q;
  logic [15:0]        ops_done_d;

  logic               grant_vld;
  logic [1:0]         grant_idx;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;
  logic               sel_cin;

  // Scan from lowest to highest priority so the last hit is the winner;
  // offset 4 wraps to last_grant itself, which therefore has lowest priority.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      if (req_valid[last_grant_q + 2'(k)]) begin
        grant_vld = 1'b1;
        grant_idx = last_grant_q + 2'(k);
      end
    end
  end

  always_comb begin
    sel_a   = req_a[int'(grant_idx)*WIDTH +: WIDTH];
    sel_b   = req_b[int'(grant_idx)*WIDTH +: WIDTH];
    sel_cin = req_cin[grant_idx];
  end

  always_comb begin
    req_ready = '0;
    if (!rst && (state_q == IDLE) && grant_vld) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign ops_done_d = ops_done_q + 16'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 2'd3;
      cap_a_q      <= '0;
      cap_b_q      <= '0;
      cap_cin_q    <= 1'b0;
      cap_id_q     <= 2'd0;
      resp_valid_q <= 1'b0;
      resp_sum_q   <= '0;
      resp_cout_q  <= 1'b0;
      resp_id_q    <= 2'd0;
      ops_done_q   <= 16'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_vld) begin
            cap_a_q      <= sel_a;
            cap_b_q      <= sel_b;
            cap_cin_q    <= sel_cin;
            cap_id_q     <= grant_idx;
            last_grant_q <= grant_idx;
            state_q      <= EXEC;
          end
        end
        EXEC: begin
          resp_sum_q   <= add_s;
          resp_cout_q  <= add_cout;
          resp_id_q    <= cap_id_q;
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            ops_done_q   <= ops_done_d;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Adder operands come straight from capture registers in every state.
  assign add_a      = cap_a_q;
  assign add_b      = cap_b_q;
  assign add_cin    = cap_cin_q;
  assign resp_valid = resp_valid_q;
  assign resp_sum   = resp_sum_q;
  assign resp_cout  = resp_cout_q;
  assign resp_id    = resp_id_q;
  assign busy       = (state_q != IDLE);
  assign ops_done   = ops_done_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter with a behavioural model of the shared external adder.
module tb_adder_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  req_cin;
  logic [7:0]  add_a;
  logic [7:0]  add_b;
  logic        add_cin;
  logic [7:0]  add_s;
  logic        add_cout;
  logic        resp_valid;
  logic        resp_ready;
  logic [7:0]  resp_sum;
  logic        resp_cout;
  logic [1:0]  resp_id;
  logic        busy;
  logic [15:0] ops_done;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

  adder_arbiter #(.WIDTH(8), .NUM_REQ(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_sum(resp_sum), .resp_cout(resp_cout), .resp_id(resp_id),
    .busy(busy), .ops_done(ops_done)
  );

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic cin);
    req_a[i*8 +: 8] = a;
    req_b[i*8 +: 8] = b;
    req_cin[i]      = cin;
  endtask

  task automatic apply_reset();
    rst        = 1'b1;
    req_valid  = 4'b0;
    req_a      = '0;
    req_b      = '0;
    req_cin    = '0;
    resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 4'hF;
    repeat (2) @(negedge clk);
    tests_run++;
    if (req_ready !== 4'b0) begin
      tests_failed++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready);
    end
    tests_run++;
    if ({busy, resp_valid, resp_sum, resp_cout, resp_id} !== 13'd0) begin
      tests_failed++;
      $display("FAIL reset_resp: busy=%b valid=%b sum=%h cout=%b id=%0d expected all zero",
               busy, resp_valid, resp_sum, resp_cout, resp_id);
    end
    tests_run++;
    if ({ops_done, add_a, add_b, add_cin} !== 33'd0) begin
      tests_failed++;
      $display("FAIL reset_counters: ops_done=%h add_a=%h add_b=%h add_cin=%b expected all zero",
               ops_done, add_a, add_b, add_cin);
    end
    req_valid = 4'b0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    apply_reset();
    set_req(0, 8'h7F, 8'h01, 1'b0);
    req_valid = 4'b0001;
    #1;
    tests_run++;
    if (req_ready !== 4'b0001) begin
      tests_failed++; $display("FAIL single_grant: got %b expected 0001", req_ready);
    end
    @(negedge clk);
    req_valid = 4'b0;
    #1;
    tests_run++;
    if ({req_ready, busy, add_a, add_b} !== {4'b0000, 1'b1, 8'h7F, 8'h01}) begin
      tests_failed++;
      $display("FAIL single_exec: ready=%b busy=%b add_a=%h add_b=%h expected 0000 1 7f 01",
               req_ready, busy, add_a, add_b);
    end
    @(negedge clk);
    #1;
    tests_run++;
    if ({resp_valid, resp_sum, resp_cout, resp_id} !== {1'b1, 8'h80, 1'b0, 2'd0}) begin
      tests_failed++;
      $display("FAIL single_resp: valid=%b sum=%h cout=%b id=%0d expected 1 80 0 0",
               resp_valid, resp_sum, resp_cout, resp_id);
    end
    @(negedge clk);
    #1;
    tests_run++;
    if ({resp_valid, busy, ops_done} !== {1'b0, 1'b0, 16'd1}) begin
      tests_failed++;
      $display("FAIL single_done: valid=%b busy=%b ops_done=%0d expected 0 0 1",
               resp_valid, busy, ops_done);
    end
  endtask

  task automatic test_carry();
    set_req(2, 8'hFF, 8'hFF, 1'b1);
    req_valid = 4'b0100;
    #1;
    tests_run++;
    if (req_ready !== 4'b0100) begin
      tests_failed++; $display("FAIL carry_grant: got %b expected 0100", req_ready);
    end
    @(negedge clk);
    req_valid = 4'b0;
    @(negedge clk);
    #1;
    tests_run++;
    if ({resp_valid, resp_sum, resp_cout, resp_id} !== {1'b1, 8'hFF, 1'b1, 2'd2}) begin
      tests_failed++;
      $display("FAIL carry_resp: valid=%b sum=%h cout=%b id=%0d expected 1 ff 1 2",
               resp_valid, resp_sum, resp_cout, resp_id);
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (ops_done !== 16'd2) begin
      tests_failed++; $display("FAIL carry_ops_done: got %0d expected 2", ops_done);
    end
  endtask

  task automatic test_fairness();
    logic [7:0] exp_sum [4];
    exp_sum = '{8'h10, 8'h21, 8'h33, 8'h44};
    apply_reset();
    set_req(0, 8'h10, 8'h00, 1'b0);
    set_req(1, 8'h20, 8'h01, 1'b0);
    set_req(2, 8'h30, 8'h02, 1'b1);
    set_req(3, 8'h40, 8'h03, 1'b1);
    req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      #1;
      tests_run++;
      if (req_ready !== (4'b0001 << (k % 4))) begin
        tests_failed++;
        $display("FAIL fair_grant[%0d]: got %b expected %b", k, req_ready, 4'b0001 << (k % 4));
      end
      @(negedge clk);
      @(negedge clk);
      #1;
      tests_run++;
      if ({resp_valid, resp_id, resp_sum} !== {1'b1, 2'(k % 4), exp_sum[k % 4]}) begin
        tests_failed++;
        $display("FAIL fair_resp[%0d]: valid=%b id=%0d sum=%h expected 1 %0d %h",
                 k, resp_valid, resp_id, resp_sum, k % 4, exp_sum[k % 4]);
      end
      @(negedge clk);
    end
    #1;
    tests_run++;
    if (ops_done !== 16'd8) begin
      tests_failed++; $display("FAIL fair_ops_done: got %0d expected 8", ops_done);
    end
    req_valid = 4'b0;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    apply_reset();
    resp_ready = 1'b0;
    set_req(0, 8'h12, 8'h34, 1'b0);
    set_req(1, 8'hF0, 8'h20, 1'b1);
    req_valid = 4'b0011;
    @(negedge clk);
    req_valid = 4'b0010;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1;
      tests_run++;
      if ({resp_valid, resp_sum, resp_cout, resp_id, req_ready, busy} !==
          {1'b1, 8'h46, 1'b0, 2'd0, 4'b0000, 1'b1}) begin
        tests_failed++;
        $display("FAIL bp_hold[%0d]: valid=%b sum=%h cout=%b id=%0d ready=%b busy=%b expected 1 46 0 0 0000 1",
                 i, resp_valid, resp_sum, resp_cout, resp_id, req_ready, busy);
      end
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    #1;
    tests_run++;
    if ({req_ready, ops_done} !== {4'b0010, 16'd1}) begin
      tests_failed++;
      $display("FAIL bp_next_grant: ready=%b ops_done=%0d expected 0010 1", req_ready, ops_done);
    end
    @(negedge clk);
    req_valid = 4'b0;
    @(negedge clk);
    #1;
    tests_run++;
    if ({resp_valid, resp_sum, resp_cout, resp_id} !== {1'b1, 8'h11, 1'b1, 2'd1}) begin
      tests_failed++;
      $display("FAIL bp_resp1: valid=%b sum=%h cout=%b id=%0d expected 1 11 1 1",
               resp_valid, resp_sum, resp_cout, resp_id);
    end
    @(negedge clk);
    #1;
    tests_run++;
    if ({resp_valid, ops_done} !== {1'b0, 16'd2}) begin
      tests_failed++;
      $display("FAIL bp_ops_done: valid=%b ops_done=%0d expected 0 2", resp_valid, ops_done);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    set_req(0, 8'h01, 8'h01, 1'b0);
    set_req(2, 8'h02, 8'h02, 1'b0);
    req_valid = 4'b0101;
    @(negedge clk);
    #1;
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++; $display("FAIL mid_in_exec: busy=%b expected 1", busy);
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if ({resp_valid, busy, req_ready, ops_done} !== {1'b0, 1'b0, 4'b0000, 16'd0}) begin
      tests_failed++;
      $display("FAIL mid_abort: valid=%b busy=%b ready=%b ops_done=%0d expected 0 0 0000 0",
               resp_valid, busy, req_ready, ops_done);
    end
    @(negedge clk);
    #1;
    tests_run++;
    if ({resp_valid, ops_done} !== {1'b0, 16'd0}) begin
      tests_failed++;
      $display("FAIL mid_held: valid=%b ops_done=%0d expected 0 0", resp_valid, ops_done);
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if (req_ready !== 4'b0001) begin
      tests_failed++; $display("FAIL mid_restart_grant: got %b expected 0001", req_ready);
    end
    @(negedge clk);
    req_valid = 4'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    tests_run++;
    if ({resp_valid, ops_done} !== {1'b0, 16'd1}) begin
      tests_failed++;
      $display("FAIL mid_after: valid=%b ops_done=%0d expected 0 1", resp_valid, ops_done);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    resp_ready = 1'b0;
    set_req(3, 8'h05, 8'h06, 1'b0);
    req_valid = 4'b1000;
    @(negedge clk);
    req_valid = 4'b0;
    @(negedge clk);
    force dut.ops_done_q = 16'hFFFF;
    #1;
    release dut.ops_done_q;
    #1;
    tests_run++;
    if ({ops_done, resp_valid, resp_id, resp_sum} !== {16'hFFFF, 1'b1, 2'd3, 8'h0B}) begin
      tests_failed++;
      $display("FAIL wrap_pre: ops_done=%h valid=%b id=%0d sum=%h expected ffff 1 3 0b",
               ops_done, resp_valid, resp_id, resp_sum);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    #1;
    tests_run++;
    if ({ops_done, resp_valid, busy} !== {16'h0000, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL wrap_post: ops_done=%h valid=%b busy=%b expected 0000 0 0",
               ops_done, resp_valid, busy);
    end
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 4'b0;
    req_a      = '0;
    req_b      = '0;
    req_cin    = '0;
    resp_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_single();
    test_carry();
    test_fairness();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
